// File: rtl/regfile_pkg.sv
// Purpose: shared widths and the writeback request record for the regfile writeback arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam int STALL_W    = 16;

  // "reg" is a reserved word, so the destination register field is called rd.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/wb_slot.sv
// Purpose: one-entry valid/ready holding buffer for a single writeback source.
// Latency: request visible on out_* the cycle after its accept edge.
// Backpressure: in_rdy_o = empty or being drained this cycle, so a
//   simultaneous drain and load reloads the entry without a bubble.
// Ports: clk/reset_n; in_vld_i/in_rdy_o/in_dat_i upstream handshake;
//   take_i drains the entry; out_vld_o/out_dat_o expose the held request.
module wb_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    in_vld_i,
  output logic    in_rdy_o,
  input  wb_req_t in_dat_i,
  input  logic    take_i,
  output logic    out_vld_o,
  output wb_req_t out_dat_o
);

  logic    valid_q, valid_d;
  wb_req_t data_q, data_d;
  logic    load;

  always_comb begin
    in_rdy_o = !valid_q || take_i;
    load     = in_vld_i && in_rdy_o;
    valid_d  = load || (valid_q && !take_i);
    data_d   = load ? in_dat_i : data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_vld_o = valid_q;
  assign out_dat_o = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Purpose: arbitrates ALU (A) and load-unit (B) writebacks onto one register-file write port.
// Latency: accepted at edge k, write presented during cycle k..k+1, captured at edge k+1.
// Backpressure: each source sees ready while its slot is empty or granted this cycle.
// Ports: clk, reset_n; a_*/b_* valid/ready request ports; reg_write/write_reg/write_data
//   to the register file; grant_b source select; pend_mask in-flight destinations;
//   stall_cnt saturating lost-arbitration counter.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0]     write_data,
  output logic                  grant_b,
  output logic [NUM_REGS-1:0]   pend_mask,
  output logic [STALL_W-1:0]    stall_cnt
);

  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  wb_req_t a_in, b_in, a_q, b_q, gnt_req;
  logic    a_vld, b_vld, a_slot_rdy, b_slot_rdy;
  logic    take_a, take_b, gnt_any, gnt_b, same_reg;
  logic    last_b_q, last_b_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  assign a_in = '{rd: a_reg, data: a_data};
  assign b_in = '{rd: b_reg, data: b_data};

  wb_slot u_slot_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_vld_i  (a_valid),
    .in_rdy_o  (a_slot_rdy),
    .in_dat_i  (a_in),
    .take_i    (take_a),
    .out_vld_o (a_vld),
    .out_dat_o (a_q)
  );

  wb_slot u_slot_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_vld_i  (b_valid),
    .in_rdy_o  (b_slot_rdy),
    .in_dat_i  (b_in),
    .take_i    (take_b),
    .out_vld_o (b_vld),
    .out_dat_o (b_q)
  );

  // Ready is held low while reset is asserted so nothing is offered as accepted.
  assign a_ready = reset_n && a_slot_rdy;
  assign b_ready = reset_n && b_slot_rdy;

  always_comb begin
    gnt_any  = a_vld || b_vld;
    same_reg = (a_q.rd == b_q.rd) && (a_q.rd != '0);
    if (a_vld && b_vld) begin
      // Same destination: B (older in program order) writes first so A's value lands last.
      gnt_b = same_reg ? 1'b1 : !last_b_q;
    end else begin
      gnt_b = b_vld;
    end
    take_a   = a_vld && !gnt_b;
    take_b   = b_vld && gnt_b;
    gnt_req  = gnt_b ? b_q : a_q;
    last_b_d = gnt_any ? gnt_b : last_b_q;
    // Both slots valid means exactly one of them lost arbitration this cycle.
    stall_d  = (a_vld && b_vld && (stall_q != STALL_MAX)) ? stall_q + 1'b1 : stall_q;
  end

  always_comb begin
    reg_write  = gnt_any && (gnt_req.rd != '0);
    write_reg  = gnt_any ? gnt_req.rd : '0;
    write_data = gnt_any ? gnt_req.data : '0;
    grant_b    = gnt_b;
  end

  always_comb begin
    pend_mask = '0;
    if (a_vld && (a_q.rd != '0)) pend_mask[a_q.rd] = 1'b1;
    if (b_vld && (b_q.rd != '0)) pend_mask[b_q.rd] = 1'b1;
  end

  // Reset value "B granted last" lets A win the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_b_q <= 1'b1;
      stall_q  <= '0;
    end else begin
      last_b_q <= last_b_d;
      stall_q  <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Purpose: directed self-checking bench for regfile_wb_arbiter.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: sources hold valid and drop it once their request is accepted.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        grant_b;
  logic [31:0] pend_mask;
  logic [15:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] rf [32];
  logic        mon_armed = 1'b0;
  int          post_rst_writes = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_reg      (a_reg),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_reg      (b_reg),
    .b_data     (b_data),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .grant_b    (grant_b),
    .pend_mask  (pend_mask),
    .stall_cnt  (stall_cnt)
  );

  // Register-file model: commits whatever write is presented mid-cycle.
  always @(negedge clk) begin
    if (reg_write) rf[write_reg] <= write_data;
    if (mon_armed && reg_write) post_rst_writes <= post_rst_writes + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [4:0] r, input logic [31:0] d);
    a_valid = v; a_reg = r; a_data = d;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] r, input logic [31:0] d);
    b_valid = v; b_reg = r; b_data = d;
  endtask

  task automatic chk_write(input string tag, input logic we, input logic [4:0] r,
                           input logic [31:0] d, input logic gb);
    chk({tag, "_we"},   32'(reg_write),  32'(we));
    chk({tag, "_reg"},  32'(write_reg),  32'(r));
    chk({tag, "_data"}, write_data,      d);
    chk({tag, "_gb"},   32'(grant_b),    32'(gb));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset_n = 1'b0;
    drive_a(1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 5'd0, 32'h0);
    #12;
    // In reset: nothing writes, no readiness, counters clear.
    chk("rst_we",    32'(reg_write), 32'h0);
    chk("rst_ardy",  32'(a_ready),   32'h0);
    chk("rst_brdy",  32'(b_ready),   32'h0);
    chk("rst_pend",  pend_mask,      32'h0);
    chk("rst_gb",    32'(grant_b),   32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    reset_n = 1'b1;
    #1;
    chk("rel_ardy", 32'(a_ready), 32'h1);
    chk("rel_brdy", 32'(b_ready), 32'h1);
    step();

    // Tie on different registers after reset: A first, then B; one stall cycle.
    drive_a(1'b1, 5'd5, 32'h11);
    drive_b(1'b1, 5'd6, 32'h22);
    step();
    chk_write("rr1_a", 1'b1, 5'd5, 32'h11, 1'b0);
    chk("rr1_pend", pend_mask, 32'h0000_0060);
    chk("rr1_brdy", 32'(b_ready), 32'h0);
    chk("rr1_ardy", 32'(a_ready), 32'h1);
    drive_a(1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 5'd0, 32'h0);
    step();
    chk_write("rr1_b", 1'b1, 5'd6, 32'h22, 1'b1);
    chk("rr1_stall", 32'(stall_cnt), 32'd1);
    step();
    chk_write("idle1", 1'b0, 5'd0, 32'h0, 1'b0);
    chk("idle1_pend", pend_mask, 32'h0);

    // A-only write; leaves A as last granted.
    drive_a(1'b1, 5'd3, 32'h0000_00AA);
    step();
    chk_write("aonly", 1'b1, 5'd3, 32'hAA, 1'b0);
    chk("aonly_pend", pend_mask, 32'h0000_0008);
    drive_a(1'b0, 5'd0, 32'h0);
    step();
    chk_write("idle2", 1'b0, 5'd0, 32'h0, 1'b0);

    // Repeat tie with A granted last: B wins first this time.
    drive_a(1'b1, 5'd5, 32'h33);
    drive_b(1'b1, 5'd6, 32'h44);
    step();
    chk_write("rr2_b", 1'b1, 5'd6, 32'h44, 1'b1);
    drive_a(1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 5'd0, 32'h0);
    step();
    chk_write("rr2_a", 1'b1, 5'd5, 32'h33, 1'b0);
    chk("rr2_stall", 32'(stall_cnt), 32'd2);
    step();

    // Same register r7: B first, A's value is final.
    drive_a(1'b1, 5'd7, 32'h1);
    drive_b(1'b1, 5'd7, 32'h2);
    step();
    chk_write("same_b", 1'b1, 5'd7, 32'h2, 1'b1);
    chk("same_pend1", pend_mask, 32'h0000_0080);
    drive_a(1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 5'd0, 32'h0);
    step();
    chk_write("same_a", 1'b1, 5'd7, 32'h1, 1'b0);
    chk("same_pend2", pend_mask, 32'h0000_0080);
    step();
    chk("same_pend3", pend_mask, 32'h0);
    chk("same_r7",    rf[7],     32'h1);
    chk("same_stall", 32'(stall_cnt), 32'd3);

    // Register 0: retires in one cycle without a write.
    drive_a(1'b1, 5'd0, 32'hFFFF_FFFF);
    step();
    chk("r0_we",   32'(reg_write), 32'h0);
    chk("r0_pend", pend_mask,      32'h0);
    chk("r0_ardy", 32'(a_ready),   32'h1);
    chk("r0_gb",   32'(grant_b),   32'h0);
    drive_a(1'b0, 5'd0, 32'h0);
    step();
    chk("r0_ardy2", 32'(a_ready),   32'h1);
    chk("r0_we2",   32'(reg_write), 32'h0);
    chk("r0_rf0",   rf[0],          32'h0);

    // Back-to-back A accepts: slot reloads while draining, no bubble.
    drive_a(1'b1, 5'd9, 32'h91);
    step();
    chk_write("b2b_1", 1'b1, 5'd9, 32'h91, 1'b0);
    drive_a(1'b1, 5'd10, 32'hA0);
    step();
    chk_write("b2b_2", 1'b1, 5'd10, 32'hA0, 1'b0);
    drive_a(1'b0, 5'd0, 32'h0);
    step();
    chk("b2b_idle", 32'(reg_write), 32'h0);
    chk("rf9",  rf[9],  32'h91);
    chk("rf10", rf[10], 32'hA0);

    // Fresh reset, then both sources stream continuously: one loser every cycle.
    #3 reset_n = 1'b0;
    #2 chk("rst2_stall", 32'(stall_cnt), 32'h0);
    reset_n = 1'b1;
    step();
    drive_a(1'b1, 5'd1, 32'h1);
    drive_b(1'b1, 5'd2, 32'h2);
    for (int i = 0; i < 1000; i++) step();
    chk("sat_1000", 32'(stall_cnt), 32'd999);
    chk("sat_pend", pend_mask,      32'h0000_0006);
    for (int i = 0; i < 64536; i++) step();
    chk("sat_edge", 32'(stall_cnt), 32'h0000_FFFF);
    for (int i = 0; i < 4464; i++) step();
    chk("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
    chk("sat_we",   32'(reg_write), 32'h1);

    // Both slots full, reset pulsed mid-cycle: held writes are discarded.
    drive_a(1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 5'd0, 32'h0);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_we",    32'(reg_write), 32'h0);
    chk("mid_pend",  pend_mask,      32'h0);
    chk("mid_stall", 32'(stall_cnt), 32'h0);
    chk("mid_ardy",  32'(a_ready),   32'h0);
    step();
    #3 reset_n = 1'b1;
    mon_armed = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("post_writes", 32'(post_rst_writes), 32'h0);
    chk("post_ardy",   32'(a_ready),         32'h1);
    chk("post_brdy",   32'(b_ready),         32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Ports SHALL be, in order:
  clk  in  1  rising-edge clock
  reset_n  in  1  asynchronous active-low reset
  a_valid  in  1  ALU writeback request
  a_ready  out  1  A accepted when a_valid && a_ready at clk edge
  a_reg  in  5  A destination register
  a_data  in  32  A write data
  b_valid  in  1  load-unit writeback request
  b_ready  out  1  B accepted when b_valid && b_ready at clk edge
  b_reg  in  5  B destination register
  b_data  in  32  B write data
  reg_write  out  1  register-file write enable
  write_reg  out  5  register-file write address
  write_data  out  32  register-file write data
  grant_b  out  1  1 = current write comes from B
  pend_mask  out  32  bit r = register r has an accepted, unretired write
  stall_cnt  out  16  saturating count of lost-arbitration cycles

Function
REQ-003 Each source SHALL own a one-entry slot (valid, reg, data), loaded on its accept edge.
REQ-004 a_ready SHALL equal !slotA.valid || grantA; b_ready likewise; back-to-back accepts at full rate SHALL be possible when uncontended.
REQ-005 Arbitration SHALL be combinational over slot contents; one slot granted per cycle; granted slot is cleared (or reloaded) at the next edge.
REQ-006 One slot valid: that slot SHALL be granted.
REQ-007 Both valid, different registers: round-robin; grant the slot not granted last; last-grant flop updates only on a grant; reset value = B granted last (A wins first tie).
REQ-008 Both valid, same nonzero register: B SHALL be granted first regardless of round-robin pointer, so A's value is the final register value; pointer updates normally.
REQ-009 write_reg/write_data/grant_b SHALL reflect the granted slot; reg_write = grant && granted reg != 0.
REQ-010 Slot with reg 0 SHALL still be granted and retired in one cycle with reg_write = 0.
REQ-011 No grant: reg_write = 0, write_reg = 0, write_data = 0, grant_b = 0.
REQ-012 Uncontended latency: accepted at edge k, reg_write high during cycle k..k+1, register file captures at edge k+1.
REQ-013 pend_mask bit r (r != 0) SHALL be 1 while either slot holds r; bit 0 always 0; combinational from slots.
REQ-014 stall_cnt SHALL increment by 1 per cycle in which a valid slot is not granted; saturates at 0xFFFF; never wraps.
REQ-015 Simultaneous accept and grant on the same slot SHALL reload the slot with the new request (no bubble).

Reset
REQ-016 reset_n low SHALL asynchronously clear both slots, last-grant (= B), and stall_cnt to 0.
REQ-017 During reset: reg_write = 0, a_ready = b_ready = 1 only after deassertion, pend_mask = 0, grant_b = 0.
REQ-018 Reset asserted mid-operation SHALL discard held writes; no partial write occurs after reset_n falls.

Structure
REQ-019 Shared package regfile_pkg SHALL hold REG_ADDR_W = 5, DATA_W = 32, NUM_REGS = 32, and struct wb_req_t {reg, data}.
REQ-020 One sub-module wb_slot (one-entry valid/ready buffer) SHALL be instantiated twice; arbitration, pend_mask and stall_cnt live in the top.

Verification
REQ-021 A only: a_reg = 3, a_data = 0x0000_00AA accepted edge k -> reg_write = 1, write_reg = 3, write_data = 0xAA during cycle k..k+1; grant_b = 0.
REQ-022 Same-cycle A(reg 5, 0x11) and B(reg 6, 0x22) after reset -> A written first, B next cycle; stall_cnt = 1; then repeat -> B first (round-robin).
REQ-023 Same-cycle A(reg 7, 0x1) and B(reg 7, 0x2) -> B written first, A second; final r7 = 0x1; pend_mask[7] = 1 for both cycles then 0.
REQ-024 A(reg 0, 0xFFFF_FFFF) -> reg_write stays 0; slot retires in one cycle; a_ready high next cycle; pend_mask = 0.
REQ-025 B held valid continuously while A wins 70000 contended cycles (A streaming, pointer forced) -> stall_cnt saturates at 0xFFFF, no wrap.
REQ-026 Both slots full, reset_n pulsed low mid-cycle -> reg_write = 0 immediately, pend_mask = 0, stall_cnt = 0; no write to the held registers after release.
